// File: rtl/muxn_pipe_if.sv
// Bundle for the muxn_pipe select: packed data inputs, select, beat qualifiers
// and the registered result. The master drives the inputs and the slave is the select.
interface muxn_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]   sel_i;
    logic               valid_i;
    logic               stall_i;
    logic               flush_i;
    logic [WIDTH-1:0]   data_o;
    logic               valid_o;
    logic               sel_err_o;

    modport master (
        output data_i, sel_i, valid_i, stall_i, flush_i,
        input  data_o, valid_o, sel_err_o
    );

    modport slave (
        input  data_i, sel_i, valid_i, stall_i, flush_i,
        output data_o, valid_o, sel_err_o
    );
endinterface

// File: rtl/muxn_pipe.sv
// N-way WIDTH-bit select feeding a LATENCY-deep {valid, data, err} shift register with stall/flush.
// Define MUXN_SEL_CHECK_EN to carry an out-of-range select flag alongside each beat.
module muxn_pipe #(
    parameter  int WIDTH   = 32,
    parameter  int N       = 4,
    parameter  int LATENCY = 1,
    localparam int SEL_W   = $clog2(N)
) (
    input  logic        clk,
    input  logic        rst,
    muxn_pipe_if.slave  bus
);

    logic [WIDTH-1:0] w_in [N];
    logic [WIDTH-1:0] w_sel_data;

    for (genvar gi = 0; gi < N; gi++) begin : g_slice
        assign w_in[gi] = bus.data_i[gi*WIDTH +: WIDTH];
    end

    // Unmatched selects (only reachable for non-power-of-2 N) fall back to input 0.
    always_comb begin
        w_sel_data = w_in[0];
        for (int k = 1; k < N; k++) begin
            if (bus.sel_i == SEL_W'(k)) begin
                w_sel_data = w_in[k];
            end
        end
    end

`ifdef MUXN_SEL_CHECK_EN
    localparam logic [SEL_W:0] NUM_IN = (SEL_W+1)'(N);
    logic w_err_head;
    assign w_err_head = bus.valid_i && ({1'b0, bus.sel_i} >= NUM_IN);
`endif

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic             w_valid_in;
        logic [WIDTH-1:0] w_data_in;

        if (gi == 0) begin : g_head
            assign w_valid_in = bus.valid_i;
            assign w_data_in  = w_sel_data;
        end else begin : g_tail
            assign w_valid_in = g_stage[gi-1].r_valid;
            assign w_data_in  = g_stage[gi-1].r_data;
        end

        // Flush outranks stall; data loads regardless of valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (bus.flush_i) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (!bus.stall_i) begin
                r_valid <= w_valid_in;
                r_data  <= w_data_in;
            end
        end

`ifdef MUXN_SEL_CHECK_EN
        logic r_err;
        logic w_err_in;

        if (gi == 0) begin : g_err_head
            assign w_err_in = w_err_head;
        end else begin : g_err_tail
            assign w_err_in = g_stage[gi-1].r_err;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_err <= 1'b0;
            end else if (bus.flush_i) begin
                r_err <= 1'b0;
            end else if (!bus.stall_i) begin
                r_err <= w_err_in;
            end
        end
`endif
    end

    assign bus.data_o  = g_stage[LATENCY-1].r_data;
    assign bus.valid_o = g_stage[LATENCY-1].r_valid;
`ifdef MUXN_SEL_CHECK_EN
    assign bus.sel_err_o = g_stage[LATENCY-1].r_err;
`else
    assign bus.sel_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: three instances (N=4/L=1, N=4/L=3, N=3/L=2) share one stimulus stream.
// Expected beats are queued at capture and compared when they are due at the outputs.
module tb_muxn_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] tb_data  = '0;
    logic [1:0]   tb_sel   = '0;
    logic         tb_valid = 1'b0;
    logic         tb_stall = 1'b0;
    logic         tb_flush = 1'b0;

    muxn_pipe_if #(.WIDTH(32), .N(4)) if_a ();
    muxn_pipe_if #(.WIDTH(32), .N(4)) if_b ();
    muxn_pipe_if #(.WIDTH(32), .N(3)) if_c ();

    muxn_pipe #(.WIDTH(32), .N(4), .LATENCY(1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    muxn_pipe #(.WIDTH(32), .N(4), .LATENCY(3)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    muxn_pipe #(.WIDTH(32), .N(3), .LATENCY(2)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    assign if_a.data_i  = tb_data;
    assign if_b.data_i  = tb_data;
    assign if_c.data_i  = tb_data[95:0];
    assign if_a.sel_i   = tb_sel;
    assign if_b.sel_i   = tb_sel;
    assign if_c.sel_i   = tb_sel;
    assign if_a.valid_i = tb_valid;
    assign if_b.valid_i = tb_valid;
    assign if_c.valid_i = tb_valid;
    assign if_a.stall_i = tb_stall;
    assign if_b.stall_i = tb_stall;
    assign if_c.stall_i = tb_stall;
    assign if_a.flush_i = tb_flush;
    assign if_b.flush_i = tb_flush;
    assign if_c.flush_i = tb_flush;

    logic [31:0] o_data  [3];
    logic        o_valid [3];
    logic        o_err   [3];
    assign o_data[0]  = if_a.data_o;
    assign o_data[1]  = if_b.data_o;
    assign o_data[2]  = if_c.data_o;
    assign o_valid[0] = if_a.valid_o;
    assign o_valid[1] = if_b.valid_o;
    assign o_valid[2] = if_c.valid_o;
    assign o_err[0]   = if_a.sel_err_o;
    assign o_err[1]   = if_b.sel_err_o;
    assign o_err[2]   = if_c.sel_err_o;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int unsigned tag;
    } exp_t;

    exp_t        sb [3][$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned adv      = 0;
    logic [31:0] prev_data  [3];
    logic        prev_valid [3];
    logic        prev_err   [3];

    localparam logic [127:0] PAT = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int n_of(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic logic [31:0] exp_data(input int i, input logic [127:0] d, input logic [1:0] s);
        int idx;
        idx = (int'(s) < n_of(i)) ? int'(s) : 0;
        return d[idx*32 +: 32];
    endfunction

    function automatic logic exp_err(input int i, input logic [1:0] s, input logic v);
`ifdef MUXN_SEL_CHECK_EN
        return v && (int'(s) >= n_of(i));
`else
        return 1'b0 && v && (s == 2'd0) && (i < 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [127:0] d, input logic [1:0] s, input logic v,
                         input logic st, input logic fl);
        @(negedge clk);
        tb_data  = d;
        tb_sel   = s;
        tb_valid = v;
        tb_stall = st;
        tb_flush = fl;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) drive(tb_data, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Inputs change only at negedge, so the values seen here are those captured at the edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            for (int i = 0; i < 3; i++) sb[i].delete();
        end else if (tb_flush) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_flush_valid", i), 32'(o_valid[i]), 32'd0);
                chk($sformatf("u%0d_flush_data", i), o_data[i], 32'd0);
                chk($sformatf("u%0d_flush_err", i), 32'(o_err[i]), 32'd0);
                sb[i].delete();
            end
        end else if (tb_stall) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d_hold_valid", i), 32'(o_valid[i]), 32'(prev_valid[i]));
                chk($sformatf("u%0d_hold_data", i), o_data[i], prev_data[i]);
                chk($sformatf("u%0d_hold_err", i), 32'(o_err[i]), 32'(prev_err[i]));
            end
        end else begin
            adv++;
            for (int i = 0; i < 3; i++) begin
                exp_t e;
                if (tb_valid) begin
                    e.data = exp_data(i, tb_data, tb_sel);
                    e.err  = exp_err(i, tb_sel, tb_valid);
                    e.tag  = adv;
                    sb[i].push_back(e);
                end
                if (sb[i].size() > 0 && (adv - sb[i][0].tag) == unsigned'(lat_of(i) - 1)) begin
                    e = sb[i].pop_front();
                    chk($sformatf("u%0d_beat_valid", i), 32'(o_valid[i]), 32'd1);
                    chk($sformatf("u%0d_beat_data", i), o_data[i], e.data);
                    chk($sformatf("u%0d_beat_err", i), 32'(o_err[i]), 32'(e.err));
                    $display("beat u%0d data=%h err=%0d exp_data=%h exp_err=%0d",
                             i, o_data[i], o_err[i], e.data, e.err);
                end else begin
                    chk($sformatf("u%0d_idle_valid", i), 32'(o_valid[i]), 32'd0);
                    chk($sformatf("u%0d_idle_err", i), 32'(o_err[i]), 32'd0);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            prev_data[i]  = o_data[i];
            prev_valid[i] = o_valid[i];
            prev_err[i]   = o_err[i];
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_rst_valid", i), 32'(o_valid[i]), 32'd0);
            chk($sformatf("u%0d_rst_data", i), o_data[i], 32'd0);
            chk($sformatf("u%0d_rst_err", i), 32'(o_err[i]), 32'd0);
        end

        // Basic single beat, then a back-to-back sweep of all selects.
        drive(PAT, 2'd2, 1'b1, 1'b0, 1'b0);
        idle(4);
        for (int s = 0; s < 4; s++) drive(PAT, 2'(s), 1'b1, 1'b0, 1'b0);
        idle(4);

        // Mid-stream stall of two cycles with fresh data offered (must be ignored).
        for (int k = 0; k < 6; k++) begin
            drive(rand_data(), 2'($urandom_range(0, 3)), 1'b1, (k == 2 || k == 3), 1'b0);
        end
        idle(4);

        // Flush together with stall while two beats are in flight, then a new beat.
        drive(rand_data(), 2'd1, 1'b1, 1'b0, 1'b0);
        drive(rand_data(), 2'd2, 1'b1, 1'b0, 1'b0);
        drive(rand_data(), 2'd3, 1'b1, 1'b1, 1'b1);
        drive(rand_data(), 2'd1, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Out-of-range select for the N=3 instance, with and without valid.
        drive(PAT, 2'd3, 1'b1, 1'b0, 1'b0);
        idle(1);
        drive(PAT, 2'd3, 1'b0, 1'b0, 1'b0);
        idle(4);

        for (int k = 0; k < 200; k++) begin
            drive(rand_data(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0));
        end
        idle(4);

        // Asynchronous reset between edges with beats in flight.
        for (int k = 0; k < 4; k++) drive(rand_data(), 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_arst_valid", i), 32'(o_valid[i]), 32'd0);
            chk($sformatf("u%0d_arst_data", i), o_data[i], 32'd0);
            chk($sformatf("u%0d_arst_err", i), 32'(o_err[i]), 32'd0);
        end
        drive(rand_data(), 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(PAT, 2'd1, 1'b1, 1'b0, 1'b0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
